// File: rtl/notes_sequence_player_if.sv
// -----------------------------------------------------------------------------
// notes_sequence_player_if
//
// Bundles the control, note-ROM and tone-generator signals of the note
// sequence player into one interface.
//
//   start        control -> player   one-cycle pulse, begin playback when idle
//   stop         control -> player   abort playback (level or pulse)
//   rom_address  player  -> ROM      8-bit word address
//   rom_note     ROM     -> player   5-bit note index
//   rom_note_on  ROM     -> player   event type, 1 = note on, 0 = note off
//   rom_delay    ROM     -> player   10-bit delta time in ticks before the event
//   tone_note    player  -> tone     current note index
//   tone_active  player  -> tone     gate
//   note_strobe  player  -> tone     one-cycle pulse per applied event
//   busy         player  -> control  high while playing
//   done         player  -> control  one-cycle pulse at end of a non-looping song
//
// Modports:
//   master : the player
//   slave  : the environment (controller, ROM, tone generator)
// -----------------------------------------------------------------------------
interface notes_sequence_player_if;
    logic       start;
    logic       stop;
    logic [7:0] rom_address;
    logic [4:0] rom_note;
    logic       rom_note_on;
    logic [9:0] rom_delay;
    logic [4:0] tone_note;
    logic       tone_active;
    logic       note_strobe;
    logic       busy;
    logic       done;

    modport master (
        input  start, stop, rom_note, rom_note_on, rom_delay,
        output rom_address, tone_note, tone_active, note_strobe, busy, done
    );

    modport slave (
        output start, stop, rom_note, rom_note_on, rom_delay,
        input  rom_address, tone_note, tone_active, note_strobe, busy, done
    );
endinterface

// File: rtl/notes_sequence_player.sv
// -----------------------------------------------------------------------------
// notes_sequence_player
//
// Walks a note-event ROM and plays it in real time. For every word it
// issues the address, waits ROM_LAT cycles for the data, captures the event,
// waits delay*TICK_DIV cycles, then applies the event to a monophonic
// note/gate pair. Each event costs ROM_LAT+2 extra cycles of overhead which
// is intentionally not compensated.
//
// Parameters:
//   SEQ_LEN  number of valid ROM words (addresses 0..SEQ_LEN-1), 1..256
//   TICK_DIV clk cycles per delay tick, >= 1
//   ROM_LAT  clk cycles from address change to valid ROM data, >= 1
//   LOOP     1 = wrap to address 0 after the last event, 0 = stop with done
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    notes_sequence_player_if.master (control, ROM and tone signals)
//
// All outputs are registered. note_strobe, tone_note and tone_active all
// change on the edge that enters APPLY, so the strobe cycle already shows
// the new note state; the address advance happens on the edge leaving APPLY.
// -----------------------------------------------------------------------------
module notes_sequence_player #(
    parameter int SEQ_LEN  = 146,
    parameter int TICK_DIV = 50000,
    parameter int ROM_LAT  = 2,
    parameter int LOOP     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    notes_sequence_player_if.master    bus
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [7:0]       LAST_ADDR = 8'(SEQ_LEN - 1);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_MAX   = LAT_W'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        APPLY
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [PRE_W-1:0] presc;
    logic [9:0]       remaining;

    // captured event
    logic [4:0]       ev_note;
    logic             ev_on;

    // event application, shared by the zero-delay path out of LOAD and the
    // final tick of WAIT
    logic             fire;
    logic [4:0]       fire_note;
    logic             fire_on;
    logic             tick_wrap;
    logic             at_last;

    always_comb begin
        tick_wrap = (presc == PRE_MAX);
        at_last   = (bus.rom_address == LAST_ADDR);
        fire      = 1'b0;
        fire_note = ev_note;
        fire_on   = ev_on;
        if (state == LOAD) begin
            // zero-delay events skip WAIT, so take the ROM data directly
            fire      = (bus.rom_delay == 10'd0);
            fire_note = bus.rom_note;
            fire_on   = bus.rom_note_on;
        end else if (state == WAIT) begin
            fire      = tick_wrap && (remaining == 10'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            lat_cnt         <= '0;
            presc           <= '0;
            remaining       <= '0;
            ev_note         <= '0;
            ev_on           <= 1'b0;
            bus.rom_address <= '0;
            bus.tone_note   <= '0;
            bus.tone_active <= 1'b0;
            bus.note_strobe <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.note_strobe <= 1'b0;
            bus.done        <= 1'b0;

            if (state != IDLE && bus.stop) begin
                // abort wins over whatever transition was due this cycle
                state           <= IDLE;
                bus.busy        <= 1'b0;
                bus.tone_active <= 1'b0;
                bus.rom_address <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            bus.rom_address <= '0;
                            lat_cnt         <= '0;
                            bus.busy        <= 1'b1;
                            state           <= FETCH;
                        end
                    end

                    FETCH: begin
                        if (lat_cnt == LAT_MAX) begin
                            state <= LOAD;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end

                    LOAD: begin
                        ev_note   <= bus.rom_note;
                        ev_on     <= bus.rom_note_on;
                        presc     <= '0;
                        remaining <= bus.rom_delay;
                        state     <= fire ? APPLY : WAIT;
                    end

                    WAIT: begin
                        if (tick_wrap) begin
                            presc     <= '0;
                            remaining <= remaining - 10'd1;
                            if (fire) begin
                                state <= APPLY;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end

                    APPLY: begin
                        lat_cnt <= '0;
                        if (at_last) begin
                            if (LOOP != 0) begin
                                bus.rom_address <= '0;
                                state           <= FETCH;
                            end else begin
                                bus.busy <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            bus.rom_address <= bus.rom_address + 8'd1;
                            state           <= FETCH;
                        end
                    end

                    default: state <= IDLE;
                endcase

                if (fire) begin
                    bus.note_strobe <= 1'b1;
                    if (fire_on) begin
                        // note on always retriggers, even over another note
                        bus.tone_note   <= fire_note;
                        bus.tone_active <= 1'b1;
                    end else if (fire_note == bus.tone_note) begin
                        // off for a note that is not the current one is ignored
                        bus.tone_active <= 1'b0;
                    end
                    // last event of a one-shot song: silence overrides the event
                    if (at_last && LOOP == 0) begin
                        bus.done        <= 1'b1;
                        bus.tone_active <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_notes_sequence_player.sv
// Bench for notes_sequence_player: three instances (one-shot SEQ_LEN=2,
// looping SEQ_LEN=3, looping SEQ_LEN=146), one shared ROM image, 2-cycle ROM
// model per instance, and a timing model that predicts outputs from the
// event delays. Only the selected instance plays at a time.
module tb_notes_sequence_player;

    localparam int TICK_DIV = 4;
    localparam int ROM_LAT  = 2;
    localparam int LIMIT    = 6000;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic stop;
    int   sel;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM word: {on, note[4:0], delay[9:0]}
    logic [15:0] rom_mem [0:255];

    notes_sequence_player_if if_a ();
    notes_sequence_player_if if_b ();
    notes_sequence_player_if if_c ();

    assign if_a.start = start && (sel == 0);
    assign if_b.start = start && (sel == 1);
    assign if_c.start = start && (sel == 2);
    assign if_a.stop  = stop;
    assign if_b.stop  = stop;
    assign if_c.stop  = stop;

    notes_sequence_player #(.SEQ_LEN(2), .TICK_DIV(TICK_DIV), .ROM_LAT(ROM_LAT), .LOOP(0))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    notes_sequence_player #(.SEQ_LEN(3), .TICK_DIV(TICK_DIV), .ROM_LAT(ROM_LAT), .LOOP(1))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    notes_sequence_player #(.SEQ_LEN(146), .TICK_DIV(TICK_DIV), .ROM_LAT(ROM_LAT), .LOOP(1))
        u_c (.clk(clk), .reset(reset), .bus(if_c));

    // two-stage registered ROMs
    logic [15:0] p1 [3];
    logic [15:0] p2 [3];
    always @(posedge clk) begin
        p1[0] <= rom_mem[if_a.rom_address];
        p1[1] <= rom_mem[if_b.rom_address];
        p1[2] <= rom_mem[if_c.rom_address];
        for (int i = 0; i < 3; i++) p2[i] <= p1[i];
    end
    assign if_a.rom_note_on = p2[0][15];
    assign if_a.rom_note    = p2[0][14:10];
    assign if_a.rom_delay   = p2[0][9:0];
    assign if_b.rom_note_on = p2[1][15];
    assign if_b.rom_note    = p2[1][14:10];
    assign if_b.rom_delay   = p2[1][9:0];
    assign if_c.rom_note_on = p2[2][15];
    assign if_c.rom_note    = p2[2][14:10];
    assign if_c.rom_delay   = p2[2][9:0];

    // outputs of the selected instance
    int s_addr, s_note, s_act, s_strobe, s_busy, s_done;
    always_comb begin
        s_addr = 0; s_note = 0; s_act = 0; s_strobe = 0; s_busy = 0; s_done = 0;
        case (sel)
            0: begin
                s_addr = if_a.rom_address; s_note = if_a.tone_note; s_act = if_a.tone_active;
                s_strobe = if_a.note_strobe; s_busy = if_a.busy; s_done = if_a.done;
            end
            1: begin
                s_addr = if_b.rom_address; s_note = if_b.tone_note; s_act = if_b.tone_active;
                s_strobe = if_b.note_strobe; s_busy = if_b.busy; s_done = if_b.done;
            end
            default: begin
                s_addr = if_c.rom_address; s_note = if_c.tone_note; s_act = if_c.tone_active;
                s_strobe = if_c.note_strobe; s_busy = if_c.busy; s_done = if_c.done;
            end
        endcase
    end

    function automatic logic [15:0] w(input logic on, input int note, input int dly);
        return {on, 5'(note), 10'(dly)};
    endfunction

    // cycles from address issue to the edge that applies the event
    function automatic int lead(input int a);
        logic [15:0] wd;
        wd = rom_mem[a];
        return ROM_LAT + 1 + int'(wd[9:0]) * TICK_DIV;
    endfunction

    // timing model: expected outputs after each edge
    int m_addr = 0, m_note = 0, m_act = 0, m_strobe = 0, m_busy = 0, m_done = 0;
    int m_cnt = 0, m_applied = 0;

    always @(posedge clk) begin : model
        int a, nt, ac, st, bs, dn, cn, ap, seq_len, lp;
        logic [15:0] wd;
        seq_len = (sel == 0) ? 2 : (sel == 1) ? 3 : 146;
        lp = (sel == 0) ? 0 : 1;
        a = m_addr; nt = m_note; ac = m_act; bs = m_busy; cn = m_cnt; ap = m_applied;
        st = 0; dn = 0;
        if (reset) begin
            a = 0; nt = 0; ac = 0; bs = 0; cn = 0; ap = 0;
        end else if (bs == 0) begin
            if (start && !stop) begin
                bs = 1; a = 0; cn = lead(0);
            end
        end else if (stop) begin
            bs = 0; ac = 0; a = 0; ap = 0;
        end else if (ap != 0) begin
            ap = 0;
            if (a == seq_len - 1) begin
                if (lp != 0) begin a = 0; cn = lead(0); end
                else bs = 0;
            end else begin
                a = a + 1; cn = lead(a);
            end
        end else begin
            cn = cn - 1;
            if (cn == 0) begin
                wd = rom_mem[a];
                st = 1; ap = 1;
                if (wd[15]) begin nt = int'(wd[14:10]); ac = 1; end
                else if (int'(wd[14:10]) == nt) ac = 0;
                if (a == seq_len - 1 && lp == 0) begin dn = 1; ac = 0; end
            end
        end
        m_addr <= a; m_note <= nt; m_act <= ac; m_strobe <= st;
        m_busy <= bs; m_done <= dn; m_cnt <= cn; m_applied <= ap;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle comparison of the selected instance against the model
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cyc_addr", s_addr, m_addr);
            chk("cyc_note", s_note, m_note);
            chk("cyc_active", s_act, m_act);
            chk("cyc_strobe", s_strobe, m_strobe);
            chk("cyc_busy", s_busy, m_busy);
            chk("cyc_done", s_done, m_done);
        end
    end

    task automatic wait_strobe(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (s_strobe == 0 && n < LIMIT);
        chk("strobe_seen", s_strobe, 1);
    endtask

    // called just after a negedge: pulse start and count cycles to the strobe
    task automatic start_wait(output int n);
        start = 1'b1;
        n = 0;
        do begin @(negedge clk); start = 1'b0; n++; end while (s_strobe == 0 && n < LIMIT);
        chk("strobe_seen", s_strobe, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, s_addr, 0);
        chk({tag, "_note"}, s_note, 0);
        chk({tag, "_active"}, s_act, 0);
        chk({tag, "_strobe"}, s_strobe, 0);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_done"}, s_done, 0);
    endtask

    task automatic switch_to(input int s);
        reset = 1'b1;
        @(negedge clk);
        sel = s;
        @(negedge clk);
        check_zero("sel_reset");
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; sel = 0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // basic one-shot song: on 9 after 3 ticks, off 9 after 2 ticks
        rom_mem[0] = w(1'b1, 9, 3);
        rom_mem[1] = w(1'b0, 9, 2);
        start_wait(n);
        chk("basic_latency", n, 16);
        chk("basic_note", s_note, 9);
        chk("basic_active", s_act, 1);
        wait_strobe(n);
        chk("off_latency", n, 12);
        chk("off_active", s_act, 0);
        chk("off_done", s_done, 1);
        @(negedge clk);
        chk("end_busy", s_busy, 0);
        chk("end_done", s_done, 0);

        // start pulsed mid-WAIT is ignored; timing unchanged
        start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; start = (n == 8); end while (s_strobe == 0 && n < 100);
        start = 1'b0;
        chk("ignored_start_latency", n, 16);
        chk("ignored_start_addr", s_addr, 0);
        wait_strobe(n);
        chk("ignored_start_off_latency", n, 12);
        chk("ignored_start_done", s_done, 1);
        @(negedge clk);

        // looping 3-word song: zero delay, mismatched off, matching off, wrap
        switch_to(1);
        rom_mem[0] = w(1'b1, 8, 0);
        rom_mem[1] = w(1'b0, 9, 1);
        rom_mem[2] = w(1'b0, 8, 1);
        start_wait(n);
        chk("zero_latency", n, 4);
        chk("zero_addr", s_addr, 0);
        chk("zero_note", s_note, 8);
        chk("zero_active", s_act, 1);
        wait_strobe(n);
        chk("mismatch_latency", n, 8);
        chk("mismatch_addr", s_addr, 1);
        chk("mismatch_active", s_act, 1);
        chk("mismatch_note", s_note, 8);
        wait_strobe(n);
        chk("match_addr", s_addr, 2);
        chk("match_active", s_act, 0);
        wait_strobe(n);
        chk("wrap3_latency", n, 4);
        chk("wrap3_addr", s_addr, 0);
        chk("wrap3_active", s_act, 1);
        wait_strobe(n);
        chk("wrap3_addr1", s_addr, 1);
        chk("wrap3_busy", s_busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop3_busy", s_busy, 0);
        chk("stop3_active", s_act, 0);
        // start and stop together while idle: stays idle
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("start_stop_idle_busy", s_busy, 0);

        // abort a 1023-tick wait with stop, replay, then abort with reset
        switch_to(2);
        rom_mem[0] = w(1'b1, 5, 0);
        rom_mem[1] = w(1'b1, 6, 1023);
        start_wait(n);
        chk("abort_first_latency", n, 4);
        chk("abort_first_note", s_note, 5);
        repeat (2000) @(negedge clk);
        chk("abort_wait_busy", s_busy, 1);
        chk("abort_wait_addr", s_addr, 1);
        chk("abort_wait_active", s_act, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_busy", s_busy, 0);
        chk("abort_active", s_act, 0);
        chk("abort_addr", s_addr, 0);
        chk("abort_strobe", s_strobe, 0);
        start_wait(n);
        chk("replay_latency", n, 4);
        chk("replay_addr", s_addr, 0);
        repeat (2000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset_abort");
        reset = 1'b0;

        // full 146-word loop with zero delays: 145 -> 0 wrap
        for (int i = 0; i < 146; i++) rom_mem[i] = w(i % 3 != 2, i % 32, 0);
        start_wait(n);
        for (int i = 1; i < 146; i++) wait_strobe(n);
        chk("wrap146_last_addr", s_addr, 145);
        wait_strobe(n);
        chk("wrap146_latency", n, 4);
        chk("wrap146_addr", s_addr, 0);
        chk("wrap146_busy", s_busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
